// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program-counter unit: default geometry,
// BTB entry layout and the next-PC source encoding used for debug/trace.
package pc_pkg;

  localparam int unsigned DEF_XLEN        = 32;
  localparam int unsigned DEF_BTB_ENTRIES = 16;
  localparam int unsigned DEF_BTB_IDX     = $clog2(DEF_BTB_ENTRIES);
  localparam logic [DEF_XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;

  // BTB entry layout at the default geometry (valid, tag, word-aligned target)
  typedef struct packed {
    logic                              valid;
    logic [DEF_XLEN-DEF_BTB_IDX-3:0]   tag;
    logic [DEF_XLEN-3:0]               target;
  } btb_entry_t;

  // Source chosen for the next fetch PC
  typedef enum logic [2:0] {
    RST   = 3'd0,
    TRAP  = 3'd1,
    REDIR = 3'd2,
    HOLD  = 3'd3,
    PRED  = 3'd4,
    SEQ   = 3'd5
  } pc_src_e;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch-target buffer: combinational lookup on the fetch PC,
// single-port training from execute. Only valid bits are reset; tags and
// targets are qualified by valid and need no reset.
module pc_btb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN        = DEF_XLEN,
  parameter int unsigned BTB_ENTRIES = DEF_BTB_ENTRIES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] lookup_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic            hit_c,
  output logic [XLEN-1:0] target_c
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam int unsigned TGT_W = XLEN - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [TGT_W-1:0]       tgt_q [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             wr_taken;
  logic             unused_bits;

  assign lk_idx   = lookup_pc[IDX_W+1:2];
  assign lk_tag   = lookup_pc[XLEN-1:IDX_W+2];
  assign up_idx   = upd_pc[IDX_W+1:2];
  assign up_tag   = upd_pc[XLEN-1:IDX_W+2];
  assign wr_taken = upd_valid && upd_taken && !reset;

  // Lookup reads pre-write contents; a same-cycle write is seen next cycle
  assign hit_c    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign target_c = {tgt_q[lk_idx], 2'b00};

  // Byte-offset bits carry no information for word-aligned fetch
  assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Valid bits: cleared on reset, set on taken, cleared on matching not-taken
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
      end else if (tag_q[up_idx] == up_tag) begin
        valid_q[up_idx] <= 1'b0;
      end
    end
  end

  // Tag/target payload: replaced on every taken update
  always_ff @(posedge clk) begin
    if (wr_taken) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= upd_target[XLEN-1:2];
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC generator for the IF stage. Priority: reset, trap, redirect,
// stall, BTB prediction, sequential +4 (wraps silently).
// Optional BTB compiled in with `define PC_UNIT_BTB_EN; without it the
// prediction path is absent and upd_* inputs are ignored.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int unsigned      BTB_ENTRIES  = DEF_BTB_ENTRIES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic            misalign_err
);

  pc_src_e         next_src;
  logic [XLEN-1:0] next_pc;
  logic            next_misalign;
  logic [XLEN-1:0] btb_target;

`ifdef PC_UNIT_BTB_EN
  // Prediction for the current fetch PC
  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .reset      (reset),
    .lookup_pc  (pc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken),
    .hit_c      (pred_taken),
    .target_c   (btb_target)
  );
`else
  localparam int unsigned unused_btb_entries = BTB_ENTRIES;
  logic unused_upd;

  assign pred_taken  = 1'b0;
  assign btb_target  = '0;
  assign unused_upd  = ^{upd_valid, upd_pc, upd_target, upd_taken};
`endif

  // Select the next-PC source by priority
  always_comb begin
    next_src = SEQ;
    if (reset) begin
      next_src = RST;
    end else if (trap_valid) begin
      next_src = TRAP;
    end else if (redirect_valid) begin
      next_src = REDIR;
    end else if (stall) begin
      next_src = HOLD;
    end else if (pred_taken) begin
      next_src = PRED;
    end
  end

  // Next PC value and misalignment flag for the selected source
  always_comb begin
    next_pc       = pc + XLEN'(4);
    next_misalign = 1'b0;
    case (next_src)
      RST:   next_pc = RESET_VECTOR;
      TRAP: begin
        next_pc       = {trap_vector[XLEN-1:2], 2'b00};
        next_misalign = |trap_vector[1:0];
      end
      REDIR: begin
        next_pc       = {redirect_target[XLEN-1:2], 2'b00};
        next_misalign = |redirect_target[1:0];
      end
      HOLD:  next_pc = pc;
      PRED:  next_pc = btb_target;
      default: next_pc = pc + XLEN'(4);
    endcase
  end

  // PC and misalign pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc           <= RESET_VECTOR;
      misalign_err <= 1'b0;
    end else begin
      pc           <= next_pc;
      misalign_err <= next_misalign;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit (RESET_VECTOR = 0x100). Expected pc/pred/misalign
// are queued as each cycle is driven and compared once the edge has passed.
// BTB scenarios are included when PC_UNIT_BTB_EN is defined.
module tb_pc_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0100;

  logic            clk;
  logic            reset;
  logic            stall;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic [XLEN-1:0] pc;
  logic            pred_taken;
  logic            misalign_err;

  typedef struct {
    logic [31:0] pc;
    logic        pred;
    logic        mis;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  pc_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .BTB_ENTRIES  (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .trap_valid      (trap_valid),
    .trap_vector     (trap_vector),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_target      (upd_target),
    .upd_taken       (upd_taken),
    .pc              (pc),
    .pred_taken      (pred_taken),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    reset           = 1'b0;
    stall           = 1'b0;
    trap_valid      = 1'b0;
    trap_vector     = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    upd_valid       = 1'b0;
    upd_pc          = '0;
    upd_target      = '0;
    upd_taken       = 1'b0;
  endtask

  // Queue the expectation for the current cycle's drive, clock it, then check
  task automatic step(input logic [31:0] epc, input logic epred, input logic emis,
                      input string tag);
    exp_t e;
    e.pc = epc; e.pred = epred; e.mis = emis; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_assert++;
    assert (pc === e.pc) else begin
      n_fail++;
      $error("FAIL %s pc observed=%h expected=%h", e.tag, pc, e.pc);
    end
    n_assert++;
    assert (pred_taken === e.pred) else begin
      n_fail++;
      $error("FAIL %s pred_taken observed=%b expected=%b", e.tag, pred_taken, e.pred);
    end
    n_assert++;
    assert (misalign_err === e.mis) else begin
      n_fail++;
      $error("FAIL %s misalign_err observed=%b expected=%b", e.tag, misalign_err, e.mis);
    end
    idle();
  endtask

  initial begin
    idle();
    #1;

    // Reset and free-running sequence
    reset = 1'b1; step(RV, 1'b0, 1'b0, "reset0");
    reset = 1'b1; step(RV, 1'b0, 1'b0, "reset1");
    step(32'h104, 1'b0, 1'b0, "seq1");
    step(32'h108, 1'b0, 1'b0, "seq2");
    step(32'h10C, 1'b0, 1'b0, "seq3");

    // Redirect overrides stall; stall alone holds
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h200;
    step(32'h200, 1'b0, 1'b0, "redir_over_stall");
    stall = 1'b1; step(32'h200, 1'b0, 1'b0, "hold1");
    stall = 1'b1; step(32'h200, 1'b0, 1'b0, "hold2");

    // Trap beats redirect
    trap_valid = 1'b1; trap_vector = 32'h80;
    redirect_valid = 1'b1; redirect_target = 32'h300;
    step(32'h80, 1'b0, 1'b0, "trap_over_redir");

    // Misaligned redirect: aligned load, one-cycle error pulse
    redirect_valid = 1'b1; redirect_target = 32'h203;
    step(32'h200, 1'b0, 1'b1, "redir_misalign");
    step(32'h204, 1'b0, 1'b0, "misalign_clear");

    // Misalign follows the selected source only
    trap_valid = 1'b1; trap_vector = 32'h82;
    redirect_valid = 1'b1; redirect_target = 32'h200;
    step(32'h80, 1'b0, 1'b1, "trap_misalign");
    trap_valid = 1'b1; trap_vector = 32'h80;
    redirect_valid = 1'b1; redirect_target = 32'h201;
    step(32'h80, 1'b0, 1'b0, "trap_aligned_redir_mis");
    stall = 1'b1; trap_valid = 1'b1; trap_vector = 32'h181;
    step(32'h180, 1'b0, 1'b1, "trap_over_stall_mis");

    // Wrap at top of address space
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step(32'hFFFF_FFFC, 1'b0, 1'b0, "to_top");
    step(32'h0, 1'b0, 1'b0, "wrap");
    step(32'h4, 1'b0, 1'b0, "after_wrap");

    // Reset mid-stall with redirect pending
    reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h400;
    step(RV, 1'b0, 1'b0, "reset_mid");
    step(32'h104, 1'b0, 1'b0, "post_reset");

`ifdef PC_UNIT_BTB_EN
    // Train 0x10 -> 0x40 while redirecting to 0x0
    redirect_valid = 1'b1; redirect_target = 32'h0;
    upd_valid = 1'b1; upd_pc = 32'h10; upd_target = 32'h40; upd_taken = 1'b1;
    step(32'h0, 1'b0, 1'b0, "btb_start");
    step(32'h4, 1'b0, 1'b0, "btb_p4");
    step(32'h8, 1'b0, 1'b0, "btb_p8");
    step(32'hC, 1'b0, 1'b0, "btb_pC");
    step(32'h10, 1'b1, 1'b0, "btb_hit");
    step(32'h40, 1'b0, 1'b0, "btb_taken");

    // Not-taken for 0x10 clears the entry
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b0;
    step(32'h44, 1'b0, 1'b0, "btb_clear");
    redirect_valid = 1'b1; redirect_target = 32'hC;
    step(32'hC, 1'b0, 1'b0, "btb_rerun");
    step(32'h10, 1'b0, 1'b0, "btb_nohit");
    step(32'h14, 1'b0, 1'b0, "btb_fallthru");

    // Alias: not-taken for 0x50 must not disturb 0x10's entry
    upd_valid = 1'b1; upd_pc = 32'h10; upd_target = 32'h40; upd_taken = 1'b1;
    step(32'h18, 1'b0, 1'b0, "alias_train");
    upd_valid = 1'b1; upd_pc = 32'h50; upd_taken = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'hC;
    step(32'hC, 1'b0, 1'b0, "alias_nt");
    step(32'h10, 1'b1, 1'b0, "alias_hit");
    step(32'h40, 1'b0, 1'b0, "alias_taken");

    // Stall at a predicted PC holds and keeps predicting
    redirect_valid = 1'b1; redirect_target = 32'h10;
    step(32'h10, 1'b1, 1'b0, "pred_at_10");
    stall = 1'b1; step(32'h10, 1'b1, 1'b0, "pred_stall");

    // Reset mid-stall empties the BTB
    reset = 1'b1; stall = 1'b1;
    step(RV, 1'b0, 1'b0, "btb_reset");
    redirect_valid = 1'b1; redirect_target = 32'h10;
    step(32'h10, 1'b0, 1'b0, "btb_empty");

    // Same-cycle write at the looked-up index uses old contents
    upd_valid = 1'b1; upd_pc = 32'h10; upd_target = 32'h40; upd_taken = 1'b1;
    step(32'h14, 1'b0, 1'b0, "same_cycle_old");
    redirect_valid = 1'b1; redirect_target = 32'h10;
    step(32'h10, 1'b1, 1'b0, "same_cycle_new");

    // Training during reset is ignored
    reset = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h20; upd_target = 32'h80; upd_taken = 1'b1;
    step(RV, 1'b0, 1'b0, "upd_in_reset");
    redirect_valid = 1'b1; redirect_target = 32'h20;
    step(32'h20, 1'b0, 1'b0, "upd_in_reset_nohit");
    step(32'h24, 1'b0, 1'b0, "upd_in_reset_seq");
`else
    // Without a BTB, training inputs have no effect
    upd_valid = 1'b1; upd_pc = 32'h108; upd_target = 32'h40; upd_taken = 1'b1;
    step(32'h108, 1'b0, 1'b0, "nobtb_train");
    step(32'h10C, 1'b0, 1'b0, "nobtb_seq");
    redirect_valid = 1'b1; redirect_target = 32'h108;
    step(32'h108, 1'b0, 1'b0, "nobtb_at_pc");
    step(32'h10C, 1'b0, 1'b0, "nobtb_nopred");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
